// File: rtl/seq_stepper_n.sv
// N-stage sequence stepper: stage i advances on x[i], wraps after stage N-1.
// Miss handling is either strict restart or hold-with-timeout; completed sequences are counted (saturating).
module seq_stepper_n #(
    parameter int N  = 3,
    parameter int SW = 3,
    parameter int TW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic [N-1:0]  x,
    input  logic          miss_mode,
    input  logic [TW-1:0] tmo,
    output logic [SW-1:0] stage,
    output logic          busy,
    output logic [N-1:0]  fire,
    output logic          done,
    output logic          abort,
    output logic [CW-1:0] seq_cnt
);

    logic [TW-1:0] timer, timer_n;
    logic [SW-1:0] stage_n;
    logic [CW-1:0] cnt_n;
    logic [N-1:0]  fire_n;
    logic          done_n, abort_n;
    logic          hit, last, tmo_hit, restart;

    // Only the request belonging to the current stage is looked at.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N; i++)
            if (stage == SW'(i)) hit = x[i];
        last    = (stage == SW'(N - 1));
        tmo_hit = (tmo != '0) &&
                  (({1'b0, timer} + (TW + 1)'(1)) >= {1'b0, tmo});
        restart = en && !hit && (stage != '0) && (!miss_mode || tmo_hit);
    end

    // Next-state logic
    always_comb begin
        stage_n = stage;
        timer_n = timer;
        cnt_n   = seq_cnt;
        if (en) begin
            if (hit) begin
                stage_n = last ? '0 : stage + SW'(1);
                timer_n = '0;
                if (last && (seq_cnt != '1)) cnt_n = seq_cnt + CW'(1);
            end else if (restart) begin
                stage_n = '0;
                timer_n = '0;
            end else if ((stage != '0) && (timer != '1)) begin
                timer_n = timer + TW'(1);
            end
        end
    end

    // Pulse outputs, registered below
    always_comb begin
        fire_n  = '0;
        done_n  = 1'b0;
        abort_n = restart;
        if (en && hit) begin
            fire_n = N'(1) << stage;
            done_n = last;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            stage   <= '0;
            timer   <= '0;
            seq_cnt <= '0;
            busy    <= 1'b0;
            fire    <= '0;
            done    <= 1'b0;
            abort   <= 1'b0;
        end else begin
            stage   <= stage_n;
            timer   <= timer_n;
            seq_cnt <= cnt_n;
            busy    <= (stage_n != '0);
            fire    <= fire_n;
            done    <= done_n;
            abort   <= abort_n;
        end
    end

endmodule

// File: tb/tb_seq_stepper_n.sv
// Directed bench for seq_stepper_n; expected outputs queued at drive time, compared after the edge.
module tb_seq_stepper_n;
    localparam int N  = 3;
    localparam int SW = 3;
    localparam int TW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          res, en, miss_mode;
    logic [N-1:0]  x;
    logic [TW-1:0] tmo;
    logic [SW-1:0] stage;
    logic          busy, done, abort;
    logic [N-1:0]  fire;
    logic [CW-1:0] seq_cnt;

    seq_stepper_n #(.N(N), .SW(SW), .TW(TW), .CW(CW)) dut (
        .clk(clk), .res(res), .en(en), .x(x), .miss_mode(miss_mode), .tmo(tmo),
        .stage(stage), .busy(busy), .fire(fire), .done(done), .abort(abort),
        .seq_cnt(seq_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [SW-1:0] stage;
        logic          busy;
        logic [N-1:0]  fire;
        logic          done;
        logic          abort;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0, bad = 0;
    int m_stage = 0, m_timer = 0, m_cnt = 0;
    int n_done = 0, n_abort = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict the registered result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [N-1:0] xv, input logic m, input logic [TW-1:0] t);
        exp_t ex;
        logic [N-1:0] f;
        logic d, a, h;
        res = r; en = e; x = xv; miss_mode = m; tmo = t;
        f = '0; d = 1'b0; a = 1'b0;
        if (r) begin
            m_stage = 0; m_timer = 0; m_cnt = 0;
        end else if (e) begin
            h = xv[m_stage[1:0]];
            if (h) begin
                f[m_stage[1:0]] = 1'b1;
                m_timer = 0;
                if (m_stage == N - 1) begin
                    d = 1'b1;
                    m_stage = 0;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end else m_stage++;
            end else if (m_stage != 0) begin
                if (!m || (t != 0 && m_timer + 1 >= int'(t))) begin
                    m_stage = 0; m_timer = 0; a = 1'b1;
                end else if (m_timer < (1 << TW) - 1) m_timer++;
            end
        end
        ex.tag = tag; ex.stage = SW'(m_stage); ex.busy = (m_stage != 0);
        ex.fire = f; ex.done = d; ex.abort = a; ex.cnt = CW'(m_cnt);
        sbq.push_back(ex);
        @(posedge clk); #1;
        ex = sbq.pop_front();
        chk({ex.tag, ".stage"}, 32'(stage), 32'(ex.stage));
        chk({ex.tag, ".busy"},  32'(busy),  32'(ex.busy));
        chk({ex.tag, ".fire"},  32'(fire),  32'(ex.fire));
        chk({ex.tag, ".done"},  32'(done),  32'(ex.done));
        chk({ex.tag, ".abort"}, 32'(abort), 32'(ex.abort));
        chk({ex.tag, ".cnt"},   32'(seq_cnt), 32'(ex.cnt));
        if (done) n_done++;
        if (abort) n_abort++;
    endtask

    initial begin
        int d0, a0;
        res = 1'b1; en = 1'b0; x = '0; miss_mode = 1'b0; tmo = '0;
        step("rst0", 1, 0, 3'b000, 0, 0);
        step("rst1", 1, 1, 3'b111, 0, 0);
        chk("rst.stage_zero", 32'(stage), 0);

        // 1: full sequence
        step("t1a", 0, 1, 3'b001, 0, 0);
        step("t1b", 0, 1, 3'b010, 0, 0);
        step("t1c", 0, 1, 3'b100, 0, 0);
        chk("t1.fire2", 32'(fire), 32'h4);
        chk("t1.cnt1", 32'(seq_cnt), 1);
        // other x bits ignored in stage 0
        step("ign", 0, 1, 3'b110, 0, 0);
        chk("ign.stage0", 32'(stage), 0);

        // 2: strict miss
        a0 = n_abort; d0 = n_done;
        step("t2a", 0, 1, 3'b001, 0, 0);
        step("t2b", 0, 1, 3'b000, 0, 0);
        step("t2c", 0, 1, 3'b000, 0, 0);
        chk("t2.aborts", 32'(n_abort - a0), 1);
        chk("t2.nodone", 32'(n_done - d0), 0);

        // 3: hold with timeout 4
        a0 = n_abort;
        step("t3a", 0, 1, 3'b001, 1, 4);
        for (int i = 0; i < 3; i++) step("t3m", 0, 1, 3'b000, 1, 4);
        chk("t3.held", 32'(stage), 1);
        step("t3to", 0, 1, 3'b000, 1, 4);
        chk("t3.abort4", 32'(abort), 1);
        chk("t3.aborts", 32'(n_abort - a0), 1);

        // 4: hit on the timeout cycle wins, timer cleared
        a0 = n_abort;
        step("t4a", 0, 1, 3'b001, 1, 4);
        for (int i = 0; i < 3; i++) step("t4m", 0, 1, 3'b000, 1, 4);
        step("t4h", 0, 1, 3'b010, 1, 4);
        chk("t4.stage2", 32'(stage), 2);
        for (int i = 0; i < 3; i++) step("t4n", 0, 1, 3'b000, 1, 4);
        chk("t4.noabort", 32'(n_abort - a0), 0);
        step("t4t", 0, 1, 3'b000, 1, 4);
        chk("t4.aborts", 32'(n_abort - a0), 1);

        // 5: saturating count, tmo=0 never times out
        step("t5r", 1, 0, 3'b000, 0, 0);
        d0 = n_done;
        for (int s = 0; s < 5; s++) begin
            step("t5a", 0, 1, 3'b001, 0, 0);
            step("t5b", 0, 1, 3'b010, 0, 0);
            step("t5c", 0, 1, 3'b100, 0, 0);
        end
        chk("t5.dones", 32'(n_done - d0), 5);
        chk("t5.sat", 32'(seq_cnt), 3);
        a0 = n_abort;
        step("t5s", 0, 1, 3'b001, 1, 0);
        for (int i = 0; i < 300; i++) step("t5m", 0, 1, 3'b000, 1, 0);
        chk("t5.noabort", 32'(n_abort - a0), 0);
        chk("t5.held", 32'(stage), 1);

        // 6: reset mid-sequence, then freeze with en=0
        step("t6a", 0, 1, 3'b010, 0, 0);
        chk("t6.stage2", 32'(stage), 2);
        step("t6r", 1, 1, 3'b000, 0, 0);
        a0 = n_abort;
        step("t6b", 0, 1, 3'b001, 1, 4);
        step("t6m", 0, 1, 3'b000, 1, 4);
        step("t6m", 0, 1, 3'b000, 1, 4);
        for (int i = 0; i < 10; i++) step("t6f", 0, 0, 3'b010, 1, 4);
        chk("t6.frozen", 32'(stage), 1);
        step("t6m", 0, 1, 3'b000, 1, 4);
        chk("t6.noabort", 32'(n_abort - a0), 0);
        step("t6t", 0, 1, 3'b000, 1, 4);
        chk("t6.abort", 32'(abort), 1);
        // en=0 clears a pending pulse
        step("t6p", 0, 1, 3'b001, 1, 4);
        step("t6z", 0, 0, 3'b010, 1, 4);
        chk("t6.firezero", 32'(fire), 0);

        // lowering tmo below timer aborts on next miss
        step("lt0", 0, 1, 3'b000, 1, 10);
        for (int i = 0; i < 5; i++) step("ltm", 0, 1, 3'b000, 1, 10);
        chk("lt.held", 32'(stage), 1);
        step("ltl", 0, 1, 3'b000, 1, 2);
        chk("lt.abort", 32'(abort), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
